// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared block/direction/state codes, cell type and step helper
package snake_pkg;

  localparam logic [1:0] BLK_EMPTY = 2'd0;
  localparam logic [1:0] BLK_WALL  = 2'd1;
  localparam logic [1:0] BLK_SNAKE = 2'd2;
  localparam logic [1:0] BLK_FOOD  = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FOOD_WAIT = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_STEP      = 3'd3;
  localparam logic [2:0] ST_PAUSED    = 3'd4;
  localparam logic [2:0] ST_OVER      = 3'd5;
  localparam logic [2:0] ST_WON       = 3'd6;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } cell_t;

  // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT)
  function automatic logic [1:0] oppositeDir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // One move with modulo wrap; without wrap mode the border is wall, so the
  // wrapped result is only ever reached from a wall cell and still collides
  function automatic cell_t stepCell(input cell_t c, input logic [1:0] d,
                                     input logic [5:0] maxX, input logic [5:0] maxY);
    cell_t n;
    n = c;
    case (d)
      DIR_UP:   n.y = (c.y == 6'd0) ? maxY : c.y - 6'd1;
      DIR_DOWN: n.y = (c.y == maxY) ? 6'd0 : c.y + 6'd1;
      DIR_LEFT: n.x = (c.x == 6'd0) ? maxX : c.x - 6'd1;
      default:  n.x = (c.x == maxX) ? 6'd0 : c.x + 6'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// rtl/snake_engine_if.sv - game control, food handshake, renderer lookup and status bundle
interface snake_engine_if;
  logic       Tick;
  logic       DirValid;
  logic [1:0] DirIn;
  logic       PauseToggle;
  logic       FoodValid;
  logic [5:0] FoodX;
  logic [5:0] FoodY;
  logic       FoodReady;
  logic [5:0] QueryX;
  logic [5:0] QueryY;
  logic [1:0] QueryBlock;
  logic [8:0] Length;
  logic [2:0] State;
  logic       GameOver;
  logic       Won;

  modport master (
    output Tick, DirValid, DirIn, PauseToggle, FoodValid, FoodX, FoodY, QueryX, QueryY,
    input  FoodReady, QueryBlock, Length, State, GameOver, Won
  );

  modport slave (
    input  Tick, DirValid, DirIn, PauseToggle, FoodValid, FoodX, FoodY, QueryX, QueryY,
    output FoodReady, QueryBlock, Length, State, GameOver, Won
  );
endinterface

// File: rtl/snake_body_fifo.sv
// rtl/snake_body_fifo.sv - circular buffer of body cells, head pushed and tail popped
module snake_body_fifo
  import snake_pkg::*;
#(
  parameter int MAX_LENGTH = 64,
  parameter int START_X    = 20,
  parameter int START_Y    = 15
) (
  input  logic  Clock,
  input  logic  Reset,
  input  logic  PushHead,
  input  cell_t HeadIn,
  input  logic  PopTail,
  output cell_t HeadOut,
  output cell_t TailOut
);

  localparam int PW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam cell_t START_CELL = {6'(START_X), 6'(START_Y)};

  cell_t         cells [MAX_LENGTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(MAX_LENGTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // New head lands just past the current head; reset seeds slot 0 with the start cell
  always_ff @(posedge Clock) begin
    if (Reset) cells[0] <= START_CELL;
    else if (PushHead) cells[bump(headPtr)] <= HeadIn;
  end

  // Head and tail pointers advance independently and wrap at MAX_LENGTH
  always_ff @(posedge Clock) begin
    if (Reset) begin
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      if (PushHead) headPtr <= bump(headPtr);
      if (PopTail)  tailPtr <= bump(tailPtr);
    end
  end

  assign HeadOut = cells[headPtr];
  assign TailOut = cells[tailPtr];

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game engine; define SNAKE_WRAP_EN for wrap-around edges with no walls
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_WIDTH  = 40,
  parameter int GRID_HEIGHT = 30,
  parameter int MAX_LENGTH  = 64,
  parameter int START_X     = 20,
  parameter int START_Y     = 15
) (
  input logic           Clock,
  input logic           Reset,
  snake_engine_if.slave game
);

  localparam int CELLS = GRID_WIDTH * GRID_HEIGHT;
  localparam int IW = $clog2(CELLS);
  localparam logic [5:0] MAX_X = 6'(GRID_WIDTH - 1);
  localparam logic [5:0] MAX_Y = 6'(GRID_HEIGHT - 1);
  localparam cell_t START_CELL = {6'(START_X), 6'(START_Y)};

  logic [2:0]       state;
  logic [8:0]       length;
  logic [1:0]       dir;
  logic [1:0]       pendDir;
  logic             pendValid;
  cell_t            food;
  logic             foodValid;
  cell_t            nextHead;
  logic [CELLS-1:0] occ;
  logic [1:0]       queryBlock;
  cell_t            headCell;
  cell_t            tailCell;
  cell_t            cand;
  cell_t            queryCell;
  logic [1:0]       stepDir;
  logic             restart;
  logic             eating;
  logic             hitTail;
  logic             collide;
  logic             commit;
  logic             foodOk;

  function automatic logic inGrid(input cell_t c);
    return (c.x <= MAX_X) && (c.y <= MAX_Y);
  endfunction

  function automatic logic [IW-1:0] cellIdx(input cell_t c);
    return IW'(int'(c.y) * GRID_WIDTH + int'(c.x));
  endfunction

  function automatic logic isWall(input cell_t c);
    logic border;
    border = (c.x == 6'd0) || (c.y == 6'd0) || (c.x == MAX_X) || (c.y == MAX_Y);
`ifdef SNAKE_WRAP_EN
    return 1'b0 & border;
`else
    return border;
`endif
  endfunction

  function automatic logic occAt(input cell_t c);
    return inGrid(c) && occ[cellIdx(c)];
  endfunction

  // A finished game restarts from IDLE on PauseToggle exactly as on Reset
  assign restart   = Reset || (game.PauseToggle && (state == ST_OVER || state == ST_WON));
  assign cand      = {game.FoodX, game.FoodY};
  assign queryCell = {game.QueryX, game.QueryY};
  assign foodOk    = inGrid(cand) && !isWall(cand) && !occAt(cand);
  assign stepDir   = pendValid ? pendDir : dir;
  assign eating    = foodValid && (nextHead == food);
  // The tail cell is free to enter because it is vacated on the same step
  assign hitTail   = (nextHead == tailCell) && !eating;
  assign collide   = isWall(nextHead) || (occAt(nextHead) && !hitTail);
  assign commit    = (state == ST_STEP) && !collide && !restart;

  snake_body_fifo #(.MAX_LENGTH(MAX_LENGTH), .START_X(START_X), .START_Y(START_Y)) body (
    .Clock   (Clock),
    .Reset   (restart),
    .PushHead(commit),
    .HeadIn  (nextHead),
    .PopTail (commit && !eating),
    .HeadOut (headCell),
    .TailOut (tailCell)
  );

  // Game FSM: food handshake, direction latch, two-cycle step resolution
  always_ff @(posedge Clock) begin
    if (restart) begin
      state     <= ST_IDLE;
      length    <= 9'd1;
      dir       <= DIR_RIGHT;
      pendDir   <= DIR_RIGHT;
      pendValid <= 1'b0;
      food      <= '0;
      foodValid <= 1'b0;
      nextHead  <= START_CELL;
    end else begin
      case (state)
        ST_IDLE: if (game.PauseToggle) state <= ST_FOOD_WAIT;
        ST_FOOD_WAIT: begin
          if (game.FoodValid && foodOk) begin
            food      <= cand;
            foodValid <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (game.PauseToggle) begin
            state <= ST_PAUSED;
          end else if (game.Tick) begin
            nextHead  <= stepCell(headCell, stepDir, MAX_X, MAX_Y);
            dir       <= stepDir;
            pendValid <= 1'b0;
            state     <= ST_STEP;
          end else if (game.DirValid && !pendValid &&
                       !(length > 9'd1 && game.DirIn == oppositeDir(dir))) begin
            pendDir   <= game.DirIn;
            pendValid <= 1'b1;
          end
        end
        ST_STEP: begin
          if (collide) begin
            state <= ST_OVER;
          end else if (eating) begin
            length    <= length + 9'd1;
            foodValid <= 1'b0;
            state     <= (length == 9'(MAX_LENGTH - 1)) ? ST_WON : ST_FOOD_WAIT;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_PAUSED: if (game.PauseToggle) state <= ST_RUN;
        default: ;
      endcase
    end
  end

  // Occupancy bitmap follows the body: tail cleared before head set so a tail chase stays set
  always_ff @(posedge Clock) begin
    if (restart) begin
      occ <= '0;
      occ[cellIdx(START_CELL)] <= 1'b1;
    end else if (commit) begin
      if (!eating) occ[cellIdx(tailCell)] <= 1'b0;
      occ[cellIdx(nextHead)] <= 1'b1;
    end
  end

  // Registered renderer lookup with wall > snake > food > empty priority
  always_ff @(posedge Clock) begin
    if (Reset) queryBlock <= BLK_EMPTY;
    else if (!inGrid(queryCell)) queryBlock <= BLK_EMPTY;
    else if (isWall(queryCell)) queryBlock <= BLK_WALL;
    else if (occAt(queryCell)) queryBlock <= BLK_SNAKE;
    else if (foodValid && queryCell == food) queryBlock <= BLK_FOOD;
    else queryBlock <= BLK_EMPTY;
  end

  assign game.FoodReady  = (state == ST_FOOD_WAIT);
  assign game.QueryBlock = queryBlock;
  assign game.Length     = length;
  assign game.State      = state;
  assign game.GameOver   = (state == ST_OVER);
  assign game.Won        = (state == ST_WON);

endmodule
